// File: rtl/conv_result_collector_pkg.sv
// Shared types and constants for the conv write-back result collector.
package conv_result_collector_pkg;

  // Collector phase within one 5-row pass.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G01  = 2'd1,
    ST_G23  = 2'd2,
    ST_G4   = 2'd3
  } conv_state_e;

  localparam int ROWS_PER_PASS = 5;

  // Output-row offset (in rows) of each lane within the current pass.
  localparam int ROW_OFF_G01_L0 = 0;
  localparam int ROW_OFF_G01_L1 = 1;
  localparam int ROW_OFF_G23_L0 = 2;
  localparam int ROW_OFF_G23_L1 = 3;
  localparam int ROW_OFF_G4_L0  = 4;

  // Valid patterns, ordered {port0_valid, port1_valid}.
  localparam logic [1:0] PAT_NONE = 2'b00;
  localparam logic [1:0] PAT_P0   = 2'b10;
  localparam logic [1:0] PAT_BOTH = 2'b11;

  // Pattern a beat must carry to be accepted in a given phase.
  function automatic logic [1:0] expected_pattern(input conv_state_e s);
    logic [1:0] p;
    p = PAT_NONE;
    case (s)
      ST_G01:  p = PAT_BOTH;
      ST_G23:  p = PAT_BOTH;
      ST_G4:   p = PAT_P0;
      default: p = PAT_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/conv_result_collector_requant_lane.sv
// One requantization lane: round, arithmetic shift, then ReLU/saturate.
// Two register stages; the SRAM address and valid ride along with the data.
module requant_lane #(
  parameter int DATA_WIDTH = 25,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 8,
  parameter int RELU_EN    = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [OUT_WIDTH-1:0]  out_data
);

  // One extra bit so the rounding add can never overflow.
  localparam int TW = DATA_WIDTH + 1;

  localparam int UMAX_I = (1 << OUT_WIDTH) - 1;
  localparam int SMAX_I = (1 << (OUT_WIDTH - 1)) - 1;
  localparam int SMIN_I = -(1 << (OUT_WIDTH - 1));

  localparam logic signed [TW-1:0] RND  = TW'(1) << (SHIFT - 1);
  localparam logic signed [TW-1:0] UMAX = TW'(UMAX_I);
  localparam logic signed [TW-1:0] SMAX = TW'(SMAX_I);
  localparam logic signed [TW-1:0] SMIN = TW'(SMIN_I);

  logic signed [TW-1:0] x_ext;
  logic signed [TW-1:0] sum;
  logic signed [TW-1:0] t_next;

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic signed [TW-1:0]  s1_t;
  logic [OUT_WIDTH-1:0]  q_next;

  assign x_ext  = {in_data[DATA_WIDTH-1], in_data};
  assign sum    = x_ext + RND;
  assign t_next = sum >>> SHIFT;

  // Stage 1: capture the rounded, shifted value with its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_t     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_addr  <= in_addr;
      s1_t     <= t_next;
    end
  end

  // Clamp the stage-1 value into the output range.
  always_comb begin
    q_next = s1_t[OUT_WIDTH-1:0];
    if (RELU_EN != 0) begin
      if (s1_t < 0)         q_next = '0;
      else if (s1_t > UMAX) q_next = UMAX[OUT_WIDTH-1:0];
    end else begin
      if (s1_t < SMIN)      q_next = SMIN[OUT_WIDTH-1:0];
      else if (s1_t > SMAX) q_next = SMAX[OUT_WIDTH-1:0];
    end
  end

  // Stage 2: register the SRAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_addr  <= s1_addr;
      out_data  <= q_next;
    end
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects conv write-back results, 5 output rows per pass, requantizes each
// lane and writes them to two output-feature-map SRAM ports (row-major).
//
// Handshake: port0_valid/port1_valid qualify out_port0/out_port1 in the same
// cycle. There is no ready: a beat whose valid pattern matches the current
// phase is accepted that cycle; any other non-zero pattern is dropped and
// raises the sticky err flag.
module conv_result_collector
  import conv_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int DEPTH      = 61,
  parameter int NUM_PASS   = 12,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 8,
  parameter int RELU_EN    = 1,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_frame,
  input  logic [DATA_WIDTH-1:0] out_port0,
  input  logic [DATA_WIDTH-1:0] out_port1,
  input  logic                  port0_valid,
  input  logic                  port1_valid,
  output logic                  wr0_en,
  output logic [ADDR_WIDTH-1:0] wr0_addr,
  output logic [OUT_WIDTH-1:0]  wr0_data,
  output logic                  wr1_en,
  output logic [ADDR_WIDTH-1:0] wr1_addr,
  output logic [OUT_WIDTH-1:0]  wr1_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output conv_state_e           dbg_state
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(ROWS_PER_PASS * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_R0     = ADDR_WIDTH'(ROW_OFF_G01_L0 * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_R1     = ADDR_WIDTH'(ROW_OFF_G01_L1 * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_R2     = ADDR_WIDTH'(ROW_OFF_G23_L0 * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_R3     = ADDR_WIDTH'(ROW_OFF_G23_L1 * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFF_R4     = ADDR_WIDTH'(ROW_OFF_G4_L0 * DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(ROWS_PER_PASS * NUM_PASS * DEPTH - 1);

  conv_state_e           state;
  logic [CW-1:0]         col;
  logic [PW-1:0]         pass;
  logic [ADDR_WIDTH-1:0] row_base;
  logic                  err_q;

  logic [1:0]            pattern;
  logic [1:0]            exp_pat;
  logic                  beat_any;
  logic                  beat_ok;
  logic                  beat_bad;
  logic                  col_last;
  logic                  pass_last;
  logic                  lane0_valid;
  logic                  lane1_valid;
  logic [ADDR_WIDTH-1:0] off0;
  logic [ADDR_WIDTH-1:0] off1;
  logic [ADDR_WIDTH-1:0] col_ext;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;

  assign pattern   = {port0_valid, port1_valid};
  assign exp_pat   = expected_pattern(state);
  assign beat_any  = (pattern != PAT_NONE);
  // start_frame wins: a beat in the same cycle is never written.
  assign beat_ok   = beat_any && (state != ST_IDLE) && (pattern == exp_pat) && !start_frame;
  assign beat_bad  = beat_any && !beat_ok && !start_frame;
  assign col_last  = (col == CW'(DEPTH - 1));
  assign pass_last = (pass == PW'(NUM_PASS - 1));

  // Phase/column/pass sequencing and the sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      col      <= '0;
      pass     <= '0;
      row_base <= '0;
      err_q    <= 1'b0;
    end else if (start_frame) begin
      state    <= ST_G01;
      col      <= '0;
      pass     <= '0;
      row_base <= '0;
      err_q    <= 1'b0;
    end else begin
      if (beat_bad) err_q <= 1'b1;
      if (beat_ok) begin
        if (col_last) begin
          col <= '0;
          case (state)
            ST_G01: state <= ST_G23;
            ST_G23: state <= ST_G4;
            ST_G4: begin
              if (pass_last) begin
                state    <= ST_IDLE;
                pass     <= '0;
                row_base <= '0;
              end else begin
                state    <= ST_G01;
                pass     <= pass + PW'(1);
                row_base <= row_base + ROW_STRIDE;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Row offset of each lane for the current phase.
  always_comb begin
    off0 = OFF_R0;
    off1 = OFF_R1;
    case (state)
      ST_G01: begin off0 = OFF_R0; off1 = OFF_R1; end
      ST_G23: begin off0 = OFF_R2; off1 = OFF_R3; end
      ST_G4:  begin off0 = OFF_R4; off1 = '0;     end
      default: begin off0 = '0; off1 = '0; end
    endcase
  end

  assign col_ext     = ADDR_WIDTH'(col);
  assign addr0       = row_base + off0 + col_ext;
  assign addr1       = row_base + off1 + col_ext;
  assign lane0_valid = beat_ok;
  assign lane1_valid = beat_ok && (state != ST_G4);

  requant_lane #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU_EN   (RELU_EN),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (lane0_valid),
    .in_data  (out_port0),
    .in_addr  (addr0),
    .out_valid(wr0_en),
    .out_addr (wr0_addr),
    .out_data (wr0_data)
  );

  requant_lane #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .RELU_EN   (RELU_EN),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (lane1_valid),
    .in_data  (out_port1),
    .in_addr  (addr1),
    .out_valid(wr1_en),
    .out_addr (wr1_addr),
    .out_data (wr1_data)
  );

  // Only the final row-4 beat of the final pass lands on the last address.
  assign frame_done = wr0_en && (wr0_addr == LAST_ADDR);
  assign busy       = (state != ST_IDLE);
  assign err        = err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_conv_result_collector.sv
// Bench for conv_result_collector: instance a uses the default geometry with
// ReLU, instance b a small frame (DEPTH=4, NUM_PASS=2) with signed saturation.
module tb_conv_result_collector;
  import conv_result_collector_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_start = 1'b0, a_v0 = 1'b0, a_v1 = 1'b0;
  logic [24:0] a_p0 = '0, a_p1 = '0;
  logic        a_wr0_en, a_wr1_en, a_busy, a_fd, a_err;
  logic [11:0] a_wr0_addr, a_wr1_addr;
  logic [7:0]  a_wr0_data, a_wr1_data;
  conv_state_e a_state;

  logic        b_rst = 1'b1, b_start = 1'b0, b_v0 = 1'b0, b_v1 = 1'b0;
  logic [24:0] b_p0 = '0, b_p1 = '0;
  logic        b_wr0_en, b_wr1_en, b_busy, b_fd, b_err;
  logic [11:0] b_wr0_addr, b_wr1_addr;
  logic [7:0]  b_wr0_data, b_wr1_data;
  conv_state_e b_state;

  conv_result_collector dut_a (
    .clk(clk), .rst(a_rst), .start_frame(a_start),
    .out_port0(a_p0), .out_port1(a_p1), .port0_valid(a_v0), .port1_valid(a_v1),
    .wr0_en(a_wr0_en), .wr0_addr(a_wr0_addr), .wr0_data(a_wr0_data),
    .wr1_en(a_wr1_en), .wr1_addr(a_wr1_addr), .wr1_data(a_wr1_data),
    .busy(a_busy), .frame_done(a_fd), .err(a_err), .dbg_state(a_state)
  );

  conv_result_collector #(.DEPTH(4), .NUM_PASS(2), .RELU_EN(0)) dut_b (
    .clk(clk), .rst(b_rst), .start_frame(b_start),
    .out_port0(b_p0), .out_port1(b_p1), .port0_valid(b_v0), .port1_valid(b_v1),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .busy(b_busy), .frame_done(b_fd), .err(b_err), .dbg_state(b_state)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[4][$];           // index = instance*2 + lane
  int  depth_c[2] = '{61, 4};
  int  npass_c[2] = '{12, 2};
  bit  relu_c[2]  = '{1'b1, 1'b0};
  int  m_phase[2];            // 0 idle, 1 rows 0/1, 2 rows 2/3, 3 row 4
  int  m_col[2];
  int  m_pass[2];
  bit  m_err[2];
  int  fd_cnt[2];
  int  wr_cnt[2];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int quant(input int x, input bit relu);
    longint t, q;
    t = longint'(x) + 128;
    if (t >= 0) q = t / 256;
    else        q = -((-t + 255) / 256);
    if (relu) begin
      if (q < 0)   q = 0;
      if (q > 255) q = 255;
    end else begin
      if (q < -128) q = -128;
      if (q > 127)  q = 127;
    end
    return int'(q);
  endfunction

  function automatic int exp_pattern(input int s);
    if (m_phase[s] == 0) return 0;
    if (m_phase[s] == 3) return 2;
    return 3;
  endfunction

  task automatic model_update(input int s, input bit st, input bit v0, input bit v1,
                              input int x0, input int x1);
    int pat, row, d, np;
    wr_t e;
    pat = {30'd0, v0, v1};
    d   = depth_c[s];
    np  = npass_c[s];
    if (st) begin
      m_phase[s] = 1; m_col[s] = 0; m_pass[s] = 0; m_err[s] = 1'b0;
    end else if (pat != 0) begin
      if (m_phase[s] != 0 && pat == exp_pattern(s)) begin
        row = (m_phase[s] == 1) ? 0 : (m_phase[s] == 2) ? 2 : 4;
        e.due  = cyc + 1;
        e.addr = (m_pass[s] * 5 + row) * d + m_col[s];
        e.data = quant(x0, relu_c[s]);
        exp_q[s*2].push_back(e);
        if (m_phase[s] != 3) begin
          e.addr = (m_pass[s] * 5 + row + 1) * d + m_col[s];
          e.data = quant(x1, relu_c[s]);
          exp_q[s*2+1].push_back(e);
        end
        m_col[s]++;
        if (m_col[s] == d) begin
          m_col[s] = 0;
          if (m_phase[s] < 3) m_phase[s]++;
          else if (m_pass[s] == np - 1) begin m_phase[s] = 0; m_pass[s] = 0; end
          else begin m_pass[s]++; m_phase[s] = 1; end
        end
      end else begin
        m_err[s] = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input bit r, input bit st, input bit v0, input bit v1,
                       input int x0, input int x1);
    if (s == 0) begin
      a_rst = r; a_start = st; a_v0 = v0; a_v1 = v1; a_p0 = x0[24:0]; a_p1 = x1[24:0];
    end else begin
      b_rst = r; b_start = st; b_v0 = v0; b_v1 = v1; b_p0 = x0[24:0]; b_p1 = x1[24:0];
    end
  endtask

  task automatic step(input int s, input bit st, input bit v0, input bit v1,
                      input int x0, input int x1);
    drive(s, 1'b0, st, v0, v1, x0, x1);
    @(posedge clk);
    model_update(s, st, v0, v1, x0, x1);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    if (s == 0) begin
      check("a_busy", int'(a_busy), int'(m_phase[0] != 0));
      check("a_err", int'(a_err), int'(m_err[0]));
    end else begin
      check("b_busy", int'(b_busy), int'(m_phase[1] != 0));
      check("b_err", int'(b_err), int'(m_err[1]));
    end
  endtask

  function automatic int rnd_x();
    return int'($urandom) >>> 7;
  endfunction

  task automatic good_beat(input int s);
    int p;
    p = exp_pattern(s);
    step(s, 1'b0, p[1], p[0], rnd_x(), rnd_x());
  endtask

  task automatic auto_beat(input int s, input int gap_pct, input int bad_pct);
    int r, p, e;
    r = $urandom_range(99);
    e = exp_pattern(s);
    if (r < gap_pct) begin
      step(s, 1'b0, 1'b0, 1'b0, 0, 0);
    end else if (r < gap_pct + bad_pct) begin
      p = $urandom_range(3, 1);
      while (p == e) p = $urandom_range(3, 1);
      step(s, 1'b0, p[1], p[0], rnd_x(), rnd_x());
    end else begin
      good_beat(s);
    end
  endtask

  task automatic do_reset(input int s, input bit v);
    drive(s, 1'b1, 1'b0, v, v, rnd_x(), rnd_x());
    @(posedge clk);
    exp_q[s*2].delete();
    exp_q[s*2+1].delete();
    m_phase[s] = 0; m_col[s] = 0; m_pass[s] = 0; m_err[s] = 1'b0;
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    if (s == 0) begin
      check("a_rst_wr0_en", int'(a_wr0_en), 0);
      check("a_rst_wr0_addr", int'(a_wr0_addr), 0);
      check("a_rst_wr0_data", int'(a_wr0_data), 0);
      check("a_rst_wr1_en", int'(a_wr1_en), 0);
      check("a_rst_wr1_addr", int'(a_wr1_addr), 0);
      check("a_rst_wr1_data", int'(a_wr1_data), 0);
      check("a_rst_busy", int'(a_busy), 0);
      check("a_rst_fd", int'(a_fd), 0);
      check("a_rst_err", int'(a_err), 0);
      check("a_rst_state", int'(a_state), int'(ST_IDLE));
    end else begin
      check("b_rst_wr0_en", int'(b_wr0_en), 0);
      check("b_rst_wr1_en", int'(b_wr1_en), 0);
      check("b_rst_busy", int'(b_busy), 0);
      check("b_rst_err", int'(b_err), 0);
      check("b_rst_state", int'(b_state), int'(ST_IDLE));
    end
  endtask

  task automatic drain(input int s);
    repeat (4) step(s, 1'b0, 1'b0, 1'b0, 0, 0);
    check($sformatf("drain_q%0d_l0", s), exp_q[s*2].size(), 0);
    check($sformatf("drain_q%0d_l1", s), exp_q[s*2+1].size(), 0);
  endtask

  task automatic run_frame(input int s, input int gap_pct, input int bad_pct);
    fd_cnt[s] = 0;
    wr_cnt[s] = 0;
    step(s, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20000 && m_phase[s] != 0; i++) auto_beat(s, gap_pct, bad_pct);
    check($sformatf("frame_end%0d", s), m_phase[s], 0);
    drain(s);
    check($sformatf("fd_count%0d", s), fd_cnt[s], 1);
    check($sformatf("wr_count%0d", s), wr_cnt[s], 15 * npass_c[s] * depth_c[s] / 3);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic mon(input int s, input int lane, input bit en, input int addr, input int data);
    int  idx;
    wr_t e;
    idx = s * 2 + lane;
    if (en) begin
      wr_cnt[s]++;
      if (exp_q[idx].size() == 0) begin
        check($sformatf("unexpected_write%0d_l%0d", s, lane), 1, 0);
      end else begin
        e = exp_q[idx].pop_front();
        check($sformatf("wr_addr%0d_l%0d", s, lane), addr, e.addr);
        check($sformatf("wr_data%0d_l%0d", s, lane), data, e.data);
        check($sformatf("wr_time%0d_l%0d", s, lane), cyc, e.due);
      end
    end else if (exp_q[idx].size() > 0 && exp_q[idx][0].due <= cyc) begin
      check($sformatf("missing_write%0d_l%0d", s, lane), 0, 1);
      void'(exp_q[idx].pop_front());
    end
  endtask

  task automatic mon_fd(input int s, input bit en0, input bit fd);
    int exp_fd;
    exp_fd = 0;
    if (en0 && exp_q[s*2].size() > 0 && exp_q[s*2][0].due == cyc &&
        exp_q[s*2][0].addr == 5 * npass_c[s] * depth_c[s] - 1)
      exp_fd = 1;
    if (fd || exp_fd != 0) check($sformatf("frame_done%0d", s), int'(fd), exp_fd);
    if (fd) fd_cnt[s]++;
  endtask

  always @(negedge clk) begin
    mon_fd(0, a_wr0_en, a_fd);
    mon_fd(1, b_wr0_en, b_fd);
    mon(0, 0, a_wr0_en, int'(a_wr0_addr), int'(a_wr0_data));
    mon(0, 1, a_wr1_en, int'(a_wr1_addr), int'(a_wr1_data));
    mon(1, 0, b_wr0_en, int'(b_wr0_addr), int'($signed(b_wr0_data)));
    mon(1, 1, b_wr1_en, int'(b_wr1_addr), int'($signed(b_wr1_data)));
    cyc <= cyc + 1;
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset(0, 1'b0);
    do_reset(1, 1'b0);

    // Reset in the middle of rows 2/3 with valids held high.
    step(0, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (61) good_beat(0);
    repeat (10) good_beat(0);
    do_reset(0, 1'b1);
    step(0, 1'b0, 1'b1, 1'b1, rnd_x(), rnd_x());
    step(0, 1'b0, 1'b1, 1'b0, rnd_x(), rnd_x());
    drain(0);

    // Known-data row pair: lane0 -> 1 at 0..60, lane1 -> 2 at 61..121.
    step(0, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (61) step(0, 1'b0, 1'b1, 1'b1, 256, 512);
    drain(0);

    // Requantization corner values.
    step(0, 1'b1, 1'b0, 1'b0, 0, 0);
    step(0, 1'b0, 1'b1, 1'b1, -300, 127);
    step(0, 1'b0, 1'b1, 1'b1, 128, 1 << 20);
    step(0, 1'b0, 1'b1, 1'b1, -(1 << 20), 383);
    step(1, 1'b1, 1'b0, 1'b0, 0, 0);
    step(1, 1'b0, 1'b1, 1'b1, -(1 << 20), 1 << 20);
    step(1, 1'b0, 1'b1, 1'b1, -32768, 32767);
    drain(0);
    drain(1);

    // Wrong pattern inside rows 0/1: dropped, column held.
    step(0, 1'b1, 1'b0, 1'b0, 0, 0);
    repeat (5) good_beat(0);
    step(0, 1'b0, 1'b1, 1'b0, rnd_x(), rnd_x());
    step(0, 1'b0, 1'b0, 1'b1, rnd_x(), rnd_x());
    repeat (8) good_beat(0);
    drain(0);

    // Restart at row 4, pass 1, column 30 with writes in flight.
    step(0, 1'b1, 1'b0, 1'b0, 0, 0);
    step(0, 1'b0, 1'b0, 1'b1, rnd_x(), rnd_x());
    for (int i = 0; i < 2000 && !(m_pass[0] == 1 && m_phase[0] == 3 && m_col[0] == 30); i++)
      auto_beat(0, 10, 0);
    check("restart_point", m_col[0], 30);
    step(0, 1'b1, 1'b0, 1'b0, 0, 0);
    step(0, 1'b0, 1'b1, 1'b1, rnd_x(), rnd_x());
    drain(0);

    // Full frames with random gaps and stray patterns.
    run_frame(1, 15, 5);
    run_frame(1, 0, 0);
    run_frame(0, 10, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
